// File: rtl/nf2_dma_rx_mux_pkg.sv
// Shared types and helpers for the CPU rx queue to DMA mux.
// Imported by the mux top and its round-robin arbiter.
package nf2_dma_rx_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MAX_QUEUES = 16;

    function automatic int wrap_idx(input int a, input int n);
        return a % n;
    endfunction

endpackage

// File: rtl/nf2_dma_rx_mux_if.sv
// DMA rx FIFO write port: mux drives words, FIFO reports back-pressure.
// out_data is {eop, bytecnt, data}.
interface nf2_dma_rx_mux_if #(
    parameter int OUT_WIDTH = 35
) ();
    logic                 out_wr;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_nearly_full;

    modport master (
        output out_wr,
        output out_data,
        input  out_nearly_full
    );

    modport slave (
        input  out_wr,
        input  out_data,
        output out_nearly_full
    );
endinterface

// File: rtl/nf2_dma_rx_mux_rr_arbiter.sv
// Combinational round-robin search starting one past the pointer.
// The pointer register itself lives in the mux top.
import nf2_dma_rx_mux_pkg::*;

module nf2_rr_arbiter #(
    parameter int NUM_QUEUES = 8,
    parameter int QID_WIDTH  = 4
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [QID_WIDTH-1:0]  ptr,
    output logic [NUM_QUEUES-1:0] gnt,
    output logic [QID_WIDTH-1:0]  qid,
    output logic                  vld
);

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int idx;
        gnt = '0;
        qid = '0;
        vld = 1'b0;
        for (int k = NUM_QUEUES; k >= 1; k--) begin
            idx = wrap_idx(int'(ptr) + k, NUM_QUEUES);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                qid      = QID_WIDTH'(idx);
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf2_dma_rx_mux.sv
// Packet-granular mux from NUM_QUEUES CPU rx queues into the DMA rx FIFO.
// Round-robin or host-requested selection, with oversize truncation.
import nf2_dma_rx_mux_pkg::*;

module nf2_dma_rx_mux #(
    parameter int NUM_QUEUES        = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int BCNT_WIDTH        = $clog2(CTRL_WIDTH),
    parameter int QID_WIDTH         = 4,
    parameter int PKT_LEN_CNT_WIDTH = 11,
    parameter int MAX_PKT_BYTES     = 2048
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             mode_auto,
    input  logic                             req_vld,
    input  logic [QID_WIDTH-1:0]             req_qid,
    output logic                             req_ack,
    output logic                             req_nack,
    input  logic [NUM_QUEUES-1:0]            q_pkt_avail,
    output logic [NUM_QUEUES-1:0]            q_rd,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_rd_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] q_rd_ctrl,
    nf2_dma_rx_mux_if.master                 dma,
    output logic                             busy,
    output logic                             pkt_done,
    output logic [QID_WIDTH-1:0]             pkt_done_qid,
    output logic [PKT_LEN_CNT_WIDTH:0]       pkt_done_len,
    output logic                             err_oversize
);

    localparam int LW = PKT_LEN_CNT_WIDTH + 1;

    state_t                  state, nxt;
    logic [QID_WIDTH-1:0]    ptr, gq, arb_qid;
    logic [NUM_QUEUES-1:0]   g_oh, arb_gnt, req_oh;
    logic                    arb_vld, ovf;
    logic [LW-1:0]           cnt, vb, cnt_mid;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [CTRL_WIDTH-1:0]   cur_ctrl;
    logic [BCNT_WIDTH-1:0]   bcnt;
    logic [2**QID_WIDTH-1:0] avail_ext;
    logic last, trunc, rd_en, auto_go, req_ok, grant;

    // Highest set ctrl bit wins: bit i marks CTRL_WIDTH-i valid bytes.
    function automatic logic [LW-1:0] valid_bytes(
        input logic [CTRL_WIDTH-1:0] c
    );
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < CTRL_WIDTH; i++)
            if (c[i]) v = LW'(CTRL_WIDTH - i);
        return v;
    endfunction

    nf2_rr_arbiter #(
        .NUM_QUEUES(NUM_QUEUES),
        .QID_WIDTH (QID_WIDTH)
    ) u_arb (
        .req(q_pkt_avail),
        .ptr(ptr),
        .gnt(arb_gnt),
        .qid(arb_qid),
        .vld(arb_vld)
    );

    always_comb begin
        avail_ext = '0;
        avail_ext[NUM_QUEUES-1:0] = q_pkt_avail;
        req_oh = '0;
        for (int i = 0; i < NUM_QUEUES; i++)
            if (req_qid == QID_WIDTH'(i)) req_oh[i] = 1'b1;
        req_ok = (state == ST_IDLE) && !mode_auto && req_vld
              && (int'(req_qid) < NUM_QUEUES) && avail_ext[req_qid];
        auto_go = (state == ST_IDLE) && mode_auto && arb_vld;
        grant   = auto_go || req_ok;
        cur_data = '0;
        cur_ctrl = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (g_oh[i]) begin
                cur_data = q_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                cur_ctrl = q_rd_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
            end
        end
        last    = |cur_ctrl;
        vb      = valid_bytes(cur_ctrl);
        bcnt    = last ? vb[BCNT_WIDTH-1:0] : '0;
        cnt_mid = cnt + LW'(CTRL_WIDTH);
        trunc   = !last && (cnt_mid == LW'(MAX_PKT_BYTES));
        // Draining ignores back-pressure since nothing is written.
        rd_en = ((state == ST_XFER) && !dma.out_nearly_full)
             || (state == ST_DRAIN);
        q_rd         = rd_en ? g_oh : '0;
        busy         = (state != ST_IDLE);
        pkt_done     = (state == ST_DONE);
        err_oversize = pkt_done && ovf;
        pkt_done_qid = gq;
        pkt_done_len = cnt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:  if (grant) nxt = ST_XFER;
            ST_XFER: begin
                if (rd_en && last)       nxt = ST_DONE;
                else if (rd_en && trunc) nxt = ST_DRAIN;
            end
            ST_DRAIN: if (last) nxt = ST_DONE;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ptr          <= QID_WIDTH'(NUM_QUEUES - 1);
            gq           <= '0;
            g_oh         <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            req_ack      <= 1'b0;
            req_nack     <= 1'b0;
            dma.out_wr   <= 1'b0;
            dma.out_data <= '0;
        end else begin
            state      <= nxt;
            req_ack    <= req_ok;
            req_nack   <= req_vld && !req_ok;
            dma.out_wr <= 1'b0;
            if (grant) begin
                gq   <= auto_go ? arb_qid : req_qid;
                g_oh <= auto_go ? arb_gnt : req_oh;
                cnt  <= '0;
                ovf  <= 1'b0;
            end
            if (auto_go) ptr <= arb_qid;
            if ((state == ST_XFER) && rd_en) begin
                dma.out_wr   <= 1'b1;
                dma.out_data <= {last || trunc, bcnt, cur_data};
                cnt          <= last ? cnt + vb : cnt_mid;
                if (trunc) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nf2_dma_rx_mux.sv
// Directed bench for nf2_dma_rx_mux: queue models, packet vector table,
// and hand sequences for back-pressure, truncation and mid-packet reset.
module tb_nf2_dma_rx_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         mode_auto, req_vld, req_ack, req_nack;
    logic [3:0]   req_qid;
    logic [7:0]   q_pkt_avail, q_rd;
    logic [255:0] q_rd_data;
    logic [31:0]  q_rd_ctrl;
    logic         busy, pkt_done, err_oversize;
    logic [3:0]   pkt_done_qid;
    logic [11:0]  pkt_done_len;

    nf2_dma_rx_mux_if #(.OUT_WIDTH(35)) dif ();

    nf2_dma_rx_mux #(.NUM_QUEUES(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .mode_auto(mode_auto),
        .req_vld(req_vld), .req_qid(req_qid),
        .req_ack(req_ack), .req_nack(req_nack),
        .q_pkt_avail(q_pkt_avail), .q_rd(q_rd),
        .q_rd_data(q_rd_data), .q_rd_ctrl(q_rd_ctrl),
        .dma(dif), .busy(busy), .pkt_done(pkt_done),
        .pkt_done_qid(pkt_done_qid), .pkt_done_len(pkt_done_len),
        .err_oversize(err_oversize)
    );

    // Second instance with a 64-byte truncation limit.
    logic         req_ack2, req_nack2, busy2, pkt_done2, err_oversize2;
    logic [7:0]   q_pkt_avail2, q_rd2;
    logic [255:0] q_rd_data2;
    logic [31:0]  q_rd_ctrl2;
    logic [3:0]   pkt_done_qid2;
    logic [11:0]  pkt_done_len2;
    logic         one = 1'b1, zero = 1'b0;
    logic [3:0]   zq = 4'd0;

    nf2_dma_rx_mux_if #(.OUT_WIDTH(35)) dif2 ();
    assign dif2.out_nearly_full = 1'b0;

    nf2_dma_rx_mux #(.NUM_QUEUES(8), .MAX_PKT_BYTES(64)) dut2 (
        .clk(clk), .reset_n(reset_n), .mode_auto(one),
        .req_vld(zero), .req_qid(zq),
        .req_ack(req_ack2), .req_nack(req_nack2),
        .q_pkt_avail(q_pkt_avail2), .q_rd(q_rd2),
        .q_rd_data(q_rd_data2), .q_rd_ctrl(q_rd_ctrl2),
        .dma(dif2), .busy(busy2), .pkt_done(pkt_done2),
        .pkt_done_qid(pkt_done_qid2), .pkt_done_len(pkt_done_len2),
        .err_oversize(err_oversize2)
    );

    // Queue model: FWFT heads, avail drops when the last word is read.
    logic [31:0] qd [8][128];
    logic [3:0]  qc [8][128];
    logic [6:0]  rp [8];
    logic [7:0]  pav, qset, qclr;

    always @(posedge clk)
        for (int i = 0; i < 8; i++) begin
            if (qclr[i]) begin
                rp[i]  <= 7'd0;
                pav[i] <= qset[i];
            end else if (q_rd[i]) begin
                rp[i] <= rp[i] + 7'd1;
                if (qc[i][rp[i]] != 4'd0) pav[i] <= 1'b0;
            end
        end

    for (genvar i = 0; i < 8; i++) begin : g_q
        assign q_rd_data[i*32 +: 32] = qd[i][rp[i]];
        assign q_rd_ctrl[i*4 +: 4]   = qc[i][rp[i]];
    end
    assign q_pkt_avail = pav;

    logic [6:0] rp2;
    logic       pav2, set2, clr2;
    always @(posedge clk)
        if (clr2) begin
            rp2  <= 7'd0;
            pav2 <= set2;
        end else if (q_rd2[0]) begin
            rp2 <= rp2 + 7'd1;
            if (rp2 == 7'd39) pav2 <= 1'b0;
        end
    assign q_pkt_avail2 = {7'd0, pav2};
    assign q_rd_data2   = 256'(rp2);
    assign q_rd_ctrl2   = (rp2 == 7'd39) ? 32'h1 : 32'h0;

    logic nf_tog;
    always @(posedge clk) begin
        #2;
        dif.out_nearly_full = nf_tog ? ~dif.out_nearly_full : 1'b0;
    end

    logic [34:0] got[$], got2[$];
    logic [3:0]  dq[$];
    logic [11:0] dl[$];
    logic        dov[$];
    int d2n, onehot_viol, nf_viol;
    logic [11:0] d2len;
    logic        d2ov, nf_chk;

    always @(negedge clk) begin
        if (dif.out_wr) got.push_back(dif.out_data);
        if (pkt_done) begin
            dq.push_back(pkt_done_qid);
            dl.push_back(pkt_done_len);
            dov.push_back(err_oversize);
        end
        if (dif2.out_wr) got2.push_back(dif2.out_data);
        if (pkt_done2) begin
            d2n++;
            d2len = pkt_done_len2;
            d2ov  = err_oversize2;
        end
        if ($countones(q_rd) > 1 || $countones(q_rd2) > 1) onehot_viol++;
        if (nf_chk && dif.out_nearly_full && q_rd != 8'd0) nf_viol++;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        got.delete(); dq.delete(); dl.delete(); dov.delete();
    endtask

    task automatic load(input int q, input int nw, input logic [3:0] lc,
                        input logic [31:0] base);
        for (int i = 0; i < 128; i++) begin
            qd[q][i] = base + 32'(i);
            qc[q][i] = (i == nw - 1) ? lc : ((i >= nw) ? 4'b0001 : 4'b0000);
        end
    endtask

    task automatic arm(input logic [7:0] m);
        qset = m;
        qclr = m;
        @(negedge clk);
        qclr = 8'd0;
        qset = 8'd0;
    endtask

    task automatic wait_done(input int n);
        int c = 0;
        while (dq.size() < n && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("done_wait", 64'(dq.size()), 64'(n));
    endtask

    task automatic check_pkt(input string nm, input logic [3:0] q,
                             input int nw, input logic [1:0] bc,
                             input int len, input logic [31:0] base);
        logic [31:0] d;
        wait_done(1);
        if (dq.size() > 0) begin
            chk({nm, "_qid"}, dq[0], q);
            chk({nm, "_len"}, dl[0], 64'(len));
            chk({nm, "_ovs"}, dov[0], 0);
        end
        chk({nm, "_nwords"}, 64'(got.size()), 64'(nw));
        for (int k = 0; k < nw && k < got.size(); k++) begin
            d = base + 32'(k);
            chk({nm, "_word"}, got[k],
                {k == nw - 1, (k == nw - 1) ? bc : 2'b00, d});
        end
    endtask

    typedef struct {
        logic       ld;
        logic [3:0] qid;
        int         nw;
        logic [3:0] lc;
        logic       ack;
        logic [1:0] bc;
        int         len;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [31:0] base;
        int c;

        tbl[0] = '{1'b1, 4'd3, 3, 4'b0001, 1'b1, 2'd0, 12};
        tbl[1] = '{1'b0, 4'd9, 0, 4'b0000, 1'b0, 2'd0, 0};
        tbl[2] = '{1'b0, 4'd5, 0, 4'b0000, 1'b0, 2'd0, 0};
        tbl[3] = '{1'b1, 4'd1, 5, 4'b1000, 1'b1, 2'd1, 17};
        tbl[4] = '{1'b1, 4'd6, 4, 4'b0100, 1'b1, 2'd2, 14};
        tbl[5] = '{1'b1, 4'd7, 2, 4'b0010, 1'b1, 2'd3, 7};
        tbl[6] = '{1'b1, 4'd2, 1, 4'b0011, 1'b1, 2'd3, 3};

        reset_n = 1'b1; mode_auto = 1'b0; req_vld = 1'b0; req_qid = 4'd0;
        nf_tog = 1'b0; nf_chk = 1'b0;
        qset = 8'd0; qclr = 8'hFF; set2 = 1'b0; clr2 = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_q_rd", q_rd, 0);
        chk("rst_out_wr", dif.out_wr, 0);
        chk("rst_out_data", dif.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack_nack", {req_ack, req_nack}, 0);
        chk("rst_done", {pkt_done, pkt_done_qid, pkt_done_len, err_oversize}, 0);
        qclr = 8'd0; clr2 = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        // Auto round-robin over q0 and q2.
        clr();
        load(0, 3, 4'b0001, 32'h100);
        load(2, 3, 4'b0001, 32'h200);
        arm(8'h05);
        mode_auto = 1'b1;
        wait_done(2);
        if (dq.size() >= 2) begin
            chk("rr_qid0", dq[0], 0);
            chk("rr_qid1", dq[1], 2);
            chk("rr_len0", dl[0], 12);
            chk("rr_len1", dl[1], 12);
        end
        chk("rr_nwords", 64'(got.size()), 6);
        if (got.size() >= 6) begin
            chk("rr_w0", got[0], {1'b0, 2'b00, 32'h100});
            chk("rr_w2", got[2], {1'b1, 2'b00, 32'h102});
            chk("rr_w5", got[5], {1'b1, 2'b00, 32'h202});
        end
        mode_auto = 1'b0;
        repeat (3) @(negedge clk);

        // Explicit requests from the vector table.
        for (int v = 0; v < 7; v++) begin
            clr();
            base = {16'h0, 4'(v), tbl[v].qid, 8'h00};
            if (tbl[v].ld) begin
                load(int'(tbl[v].qid), tbl[v].nw, tbl[v].lc, base);
                arm(8'b1 << tbl[v].qid);
            end
            req_vld = 1'b1;
            req_qid = tbl[v].qid;
            @(negedge clk);
            req_vld = 1'b0;
            chk("vec_ack", req_ack, tbl[v].ack);
            chk("vec_nack", req_nack, !tbl[v].ack);
            if (tbl[v].ack)
                check_pkt("vec", tbl[v].qid, tbl[v].nw, tbl[v].bc,
                          tbl[v].len, base);
            repeat (3) @(negedge clk);
        end

        // Back-pressure toggling on a 64-word packet, plus a busy request.
        clr();
        load(4, 64, 4'b0001, 32'h4000);
        arm(8'h10);
        nf_tog = 1'b1;
        nf_chk = 1'b1;
        req_vld = 1'b1;
        req_qid = 4'd4;
        @(negedge clk);
        req_vld = 1'b0;
        chk("bp_ack", req_ack, 1);
        req_vld = 1'b1;
        req_qid = 4'd1;
        @(negedge clk);
        req_vld = 1'b0;
        chk("busy_nack", {req_ack, req_nack}, 2'b01);
        check_pkt("bp", 4'd4, 64, 2'd0, 256, 32'h4000);
        chk("bp_rd_while_full", 64'(nf_viol), 0);
        nf_tog = 1'b0;
        nf_chk = 1'b0;
        repeat (3) @(negedge clk);

        // Truncation at 64 bytes on the second instance.
        set2 = 1'b1;
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        set2 = 1'b0;
        c = 0;
        while (d2n < 1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("trunc_done", 64'(d2n), 1);
        chk("trunc_nwords", 64'(got2.size()), 16);
        for (int k = 0; k < 16 && k < got2.size(); k++)
            chk("trunc_word", got2[k], {k == 15, 2'b00, 32'(k)});
        chk("trunc_len", d2len, 64);
        chk("trunc_ovs", d2ov, 1);
        chk("trunc_drained", rp2, 40);
        repeat (3) @(negedge clk);

        // Reset in the middle of a 10-word packet from q3.
        clr();
        load(3, 10, 4'b0001, 32'h3000);
        arm(8'h08);
        mode_auto = 1'b1;
        c = 0;
        while (rp[3] != 7'd5 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("mid_rst_reach", rp[3], 5);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_q_rd", q_rd, 0);
        chk("mid_rst_out", {dif.out_wr, dif.out_data}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", {pkt_done, pkt_done_len, err_oversize}, 0);
        mode_auto = 1'b0;
        @(negedge clk);
        qset = 8'd0;
        qclr = 8'hFF;
        @(negedge clk);
        qclr = 8'd0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        c = 0;
        foreach (got[k]) if (got[k][34]) c++;
        chk("mid_rst_no_eop", 64'(c), 0);
        clr();
        load(0, 3, 4'b0001, 32'h0500);
        load(5, 3, 4'b0001, 32'h5500);
        arm(8'h21);
        mode_auto = 1'b1;
        wait_done(2);
        if (dq.size() >= 2) begin
            chk("post_rst_first_q", dq[0], 0);
            chk("post_rst_second_q", dq[1], 5);
        end
        mode_auto = 1'b0;
        repeat (3) @(negedge clk);

        chk("q_rd_onehot", 64'(onehot_viol), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
